// File: rtl/i2c_master_ctrl_if.sv
// Command handshake, result and I2C pad signals of i2c_master_ctrl.
// The master modport is the host/board side; the slave modport is the controller itself.
interface i2c_master_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_wdata;
    logic [7:0] rd_data;
    logic       done;
    logic       ack_err;
    logic       busy;
    logic       scl_o;
    logic       sda_oe;
    logic       sda_i;

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_reg, cmd_wdata, sda_i,
        input  cmd_ready, rd_data, done, ack_err, busy, scl_o, sda_oe
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_reg, cmd_wdata, sda_i,
        output cmd_ready, rd_data, done, ack_err, busy, scl_o, sda_oe
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C register-access controller: one write or read command per handshake,
// each bit-time split into four quarters of CLK_DIV clocks.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    i2c_master_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK1, REG, ACK2, WDATA, ACK3,
        RSTART, ADDR_R, ACK4, RDATA, MNACK, STOP
    } state_t;

    localparam logic [9:0] QLAST = 10'(CLK_DIV - 1);

    state_t     state, state_n;
    logic [9:0] qcnt;
    logic [1:0] quarter;
    logic [2:0] bit_cnt;
    logic       rw_q;
    logic [6:0] addr_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic [7:0] rx_shift;
    logic [7:0] rd_data_q;
    logic       ack_err_q;
    logic       done_q;
    logic [1:0] sda_sync;
    logic       accept;
    logic       bit_end;
    logic       sda_s;
    logic [7:0] tx_byte;
    logic       tx_bit;
    logic       scl_int;
    logic       sda_oe_int;

    assign accept  = (state == IDLE) && bus.cmd_valid;
    assign bit_end = (qcnt == QLAST) && (quarter == 2'd3);
    assign sda_s   = sda_sync[1];

    always_comb begin
        tx_byte = reg_q;
        case (state)
            ADDR_W:  tx_byte = {addr_q, 1'b0};
            ADDR_R:  tx_byte = {addr_q, 1'b1};
            WDATA:   tx_byte = wdata_q;
            default: tx_byte = reg_q;
        endcase
        tx_bit = tx_byte[3'd7 - bit_cnt];
    end

    // A 1 sampled in any slave ACK slot abandons the rest of the transfer and goes to STOP.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = START;
            START:   if (bit_end) state_n = ADDR_W;
            ADDR_W:  if (bit_end && bit_cnt == 3'd7) state_n = ACK1;
            ACK1:    if (bit_end) state_n = sda_s ? STOP : REG;
            REG:     if (bit_end && bit_cnt == 3'd7) state_n = ACK2;
            ACK2:    if (bit_end) state_n = sda_s ? STOP : (rw_q ? RSTART : WDATA);
            WDATA:   if (bit_end && bit_cnt == 3'd7) state_n = ACK3;
            ACK3:    if (bit_end) state_n = STOP;
            RSTART:  if (bit_end) state_n = ADDR_R;
            ADDR_R:  if (bit_end && bit_cnt == 3'd7) state_n = ACK4;
            ACK4:    if (bit_end) state_n = sda_s ? STOP : RDATA;
            RDATA:   if (bit_end && bit_cnt == 3'd7) state_n = MNACK;
            MNACK:   if (bit_end) state_n = STOP;
            STOP:    if (bit_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        scl_int    = 1'b1;
        sda_oe_int = 1'b0;
        case (state)
            IDLE: begin
                scl_int    = 1'b1;
                sda_oe_int = 1'b0;
            end
            START, RSTART: begin
                scl_int    = (quarter == 2'd1) || (quarter == 2'd2);
                sda_oe_int = quarter[1];
            end
            STOP: begin
                scl_int    = (quarter != 2'd0);
                sda_oe_int = ~quarter[1];
            end
            ADDR_W, REG, WDATA, ADDR_R: begin
                scl_int    = quarter[1];
                sda_oe_int = ~tx_bit;
            end
            default: begin
                scl_int    = quarter[1];
                sda_oe_int = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt    <= '0;
            quarter <= '0;
        end else if (state == IDLE) begin
            qcnt    <= '0;
            quarter <= '0;
        end else if (qcnt == QLAST) begin
            qcnt    <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            qcnt <= qcnt + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_sync <= 2'b11;
        end else begin
            sda_sync <= {sda_sync[0], bus.sda_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q      <= 1'b0;
            addr_q    <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            rd_data_q <= '0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state == STOP) && bit_end;
            if (accept) begin
                rw_q      <= bus.cmd_rw;
                addr_q    <= bus.cmd_addr;
                reg_q     <= bus.cmd_reg;
                wdata_q   <= bus.cmd_wdata;
                ack_err_q <= 1'b0;
                bit_cnt   <= '0;
            end
            if (state == START || state == RSTART) begin
                bit_cnt <= '0;
            end else if (bit_end && (state inside {ADDR_W, REG, WDATA, ADDR_R, RDATA})) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (bit_end && (state inside {ACK1, ACK2, ACK3, ACK4}) && sda_s) begin
                ack_err_q <= 1'b1;
            end
            if (bit_end && state == RDATA) begin
                rx_shift <= {rx_shift[6:0], sda_s};
            end
            if (bit_end && state == MNACK && !ack_err_q) begin
                rd_data_q <= rx_shift;
            end
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rd_data   = rd_data_q;
    assign bus.done      = done_q;
    assign bus.ack_err   = ack_err_q;
    assign bus.scl_o     = scl_int;
    assign bus.sda_oe    = sda_oe_int;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural open-drain bus with an I2C slave at 7'h05 that
// decodes the traffic into tokens checked against an expected-token scoreboard.
module tb_i2c_master_ctrl;
    localparam int         CLK_DIV  = 4;
    localparam logic [6:0] SLV_ADDR = 7'h05;
    localparam int         TOK_S    = 256;
    localparam int         TOK_P    = 257;
    localparam int         TOK_A0   = 512;
    localparam int         TOK_A1   = 513;

    typedef enum {PH_IDLE, PH_ADDR, PH_REG, PH_DATA, PH_TX} phase_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic slave_sda = 1'b1;
    logic sda_line;

    i2c_master_ctrl_if bus();

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign sda_line   = bus.sda_oe ? 1'b0 : slave_sda;
    assign bus.sda_i  = sda_line;

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    int         exp_q[$];
    logic [7:0] slv_mem [256];
    logic [7:0] exp_rd   = 8'h00;
    bit         mon_en   = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic observeToken(input int tok);
        if (exp_q.size() == 0) checkOutput("bus_unexpected_token", tok, 32'hFFFF_FFFF);
        else checkOutput("bus_token", tok, exp_q.pop_front());
    endtask

    // Slave model and SCL timing monitor, sampled on the falling clk edge.
    phase_t     ph = PH_IDLE;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, m_scl, m_sda;
    int         bcnt = 0, hi_len = 0, lo_len = 0;
    bit         ack_slot = 0, tx_pend = 0, hi_valid = 0, lo_valid = 0;
    logic [7:0] sh = 8'h00, reg_ptr = 8'h00, tx_byte = 8'h00;

    always @(negedge clk) begin
        m_scl = bus.scl_o;
        m_sda = sda_line;
        if (prev_scl && m_scl && prev_sda && !m_sda) begin
            observeToken(TOK_S);
            ph = PH_ADDR; bcnt = 0; ack_slot = 0; tx_pend = 0; slave_sda = 1'b1;
        end else if (prev_scl && m_scl && !prev_sda && m_sda) begin
            observeToken(TOK_P);
            ph = PH_IDLE; hi_valid = 0;
        end else if (!prev_scl && m_scl) begin
            if (ack_slot) observeToken(m_sda ? TOK_A1 : TOK_A0);
            else if (ph != PH_IDLE) begin
                sh = {sh[6:0], m_sda};
                bcnt++;
            end
        end else if (prev_scl && !m_scl) begin
            if (ack_slot) begin
                ack_slot  = 0;
                slave_sda = 1'b1;
                if (tx_pend) begin
                    tx_pend   = 0;
                    ph        = PH_TX;
                    tx_byte   = slv_mem[reg_ptr];
                    slave_sda = tx_byte[7];
                end else if (ph == PH_TX) begin
                    ph = PH_IDLE;
                end
            end else if (bcnt == 8) begin
                bcnt     = 0;
                ack_slot = 1;
                observeToken(int'(sh));
                case (ph)
                    PH_ADDR: begin
                        if (sh[7:1] == SLV_ADDR) begin
                            slave_sda = 1'b0;
                            if (sh[0]) tx_pend = 1;
                            else ph = PH_REG;
                        end else begin
                            ph = PH_IDLE;
                        end
                    end
                    PH_REG:  begin reg_ptr = sh; slave_sda = 1'b0; ph = PH_DATA; end
                    PH_DATA: begin slv_mem[reg_ptr] = sh; slave_sda = 1'b0; end
                    default: slave_sda = 1'b1;
                endcase
            end else if (ph == PH_TX) begin
                slave_sda = tx_byte[7 - bcnt];
            end
        end

        if (!mon_en) begin
            hi_len = 0; lo_len = 0; hi_valid = 0; lo_valid = 0;
        end else if (m_scl && !prev_scl) begin
            if (lo_valid)
                checkOutput("scl_low_time_legal",
                            (lo_len == CLK_DIV || lo_len == 2*CLK_DIV || lo_len == 3*CLK_DIV), 1);
            hi_len = 1; hi_valid = 1; lo_valid = 0;
        end else if (!m_scl && prev_scl) begin
            if (hi_valid) checkOutput("scl_high_time", hi_len, 2*CLK_DIV);
            lo_len = 1; lo_valid = 1; hi_valid = 0;
        end else if (m_scl) begin
            hi_len++;
        end else begin
            lo_len++;
        end
        prev_scl = m_scl;
        prev_sda = m_sda;
    end

    task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [7:0] rg, input logic [7:0] wd);
        @(negedge clk);
        checkOutput("ready_before_cmd", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = rw;
        bus.cmd_addr  = addr;
        bus.cmd_reg   = rg;
        bus.cmd_wdata = wd;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        checkOutput("busy_after_accept", bus.busy, 1);
        checkOutput("ack_err_clear_on_accept", bus.ack_err, 0);
    endtask

    task automatic waitDone(input bit inject, output int cycles);
        cycles = 1;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (inject && cycles == 100) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_rw    = 1'b1;
                bus.cmd_addr  = 7'h06;
                bus.cmd_reg   = 8'hFF;
                bus.cmd_wdata = 8'h00;
            end
            if (inject && cycles == 104) begin
                checkOutput("ready_low_while_busy", bus.cmd_ready, 0);
                bus.cmd_valid = 1'b0;
            end
            if (bus.done === 1'b1) return;
        end
    endtask

    task automatic runTxn(input logic rw, input logic [6:0] addr, input logic [7:0] rg,
                          input logic [7:0] wd, input bit inject);
        int  cycles;
        int  nbits;
        bit  nack;
        nack = (addr != SLV_ADDR);
        exp_q.push_back(TOK_S);
        exp_q.push_back(int'({addr, 1'b0}));
        if (nack) begin
            exp_q.push_back(TOK_A1);
            nbits = 11;
        end else begin
            exp_q.push_back(TOK_A0);
            exp_q.push_back(int'(rg));
            exp_q.push_back(TOK_A0);
            if (!rw) begin
                exp_q.push_back(int'(wd));
                exp_q.push_back(TOK_A0);
                nbits = 29;
            end else begin
                exp_q.push_back(TOK_S);
                exp_q.push_back(int'({addr, 1'b1}));
                exp_q.push_back(TOK_A0);
                exp_q.push_back(int'(slv_mem[rg]));
                exp_q.push_back(TOK_A1);
                exp_rd = slv_mem[rg];
                nbits  = 39;
            end
        end
        exp_q.push_back(TOK_P);
        applyStimulus(rw, addr, rg, wd);
        waitDone(inject, cycles);
        checkOutput("done_latency", cycles, nbits * 4 * CLK_DIV + 1);
        checkOutput("ack_err_at_done", bus.ack_err, nack);
        checkOutput("rd_data_at_done", bus.rd_data, exp_rd);
        checkOutput("bus_tokens_pending", exp_q.size(), 0);
        @(negedge clk);
        checkOutput("done_one_clk", bus.done, 0);
        repeat (3) @(negedge clk);
        checkOutput("ack_err_holds", bus.ack_err, nack);
        checkOutput("idle_scl_released", bus.scl_o, 1);
        checkOutput("idle_sda_released", bus.sda_oe, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) slv_mem[i] = 8'(i) ^ 8'h5A;
        slv_mem[8'h03] = 8'h3C;
        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_reg   = '0;
        bus.cmd_wdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_ack_err", bus.ack_err, 0);
        checkOutput("rst_rd_data", bus.rd_data, 8'h00);
        checkOutput("rst_scl", bus.scl_o, 1);
        checkOutput("rst_sda_oe", bus.sda_oe, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        $display("[TB] write 05/12/A5");
        runTxn(1'b0, 7'h05, 8'h12, 8'hA5, 1'b0);
        $display("[TB] read 05/03");
        runTxn(1'b1, 7'h05, 8'h03, 8'h00, 1'b0);
        $display("[TB] write to absent address 06");
        runTxn(1'b0, 7'h06, 8'h12, 8'hA5, 1'b0);
        $display("[TB] write with cmd_valid pulsed while busy");
        runTxn(1'b0, 7'h05, 8'h12, 8'hA5, 1'b1);

        // Abort a write while REG bit 3 (a 0 bit of 8'h12) is on the bus.
        $display("[TB] reset during REG bit 3");
        exp_q.push_back(TOK_S);
        exp_q.push_back(int'({7'h05, 1'b0}));
        exp_q.push_back(TOK_A0);
        applyStimulus(1'b0, 7'h05, 8'h12, 8'h5A);
        repeat (14 * 4 * CLK_DIV + 1) @(posedge clk);
        @(negedge clk);
        checkOutput("pre_reset_scl", bus.scl_o, 0);
        checkOutput("pre_reset_sda_oe", bus.sda_oe, 1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        checkOutput("async_reset_scl", bus.scl_o, 1);
        checkOutput("async_reset_sda_oe", bus.sda_oe, 0);
        checkOutput("async_reset_ready", bus.cmd_ready, 1);
        checkOutput("async_reset_rd_data", bus.rd_data, 8'h00);
        checkOutput("tokens_before_reset", exp_q.size(), 0);
        exp_q.delete();
        exp_rd = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        $display("[TB] write after reset");
        runTxn(1'b0, 7'h05, 8'h21, 8'hC3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
